// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional-N baud generator with handshaked reconfiguration
module baud_gen_frac #(
  parameter int                   ACC_WIDTH   = 32,
  parameter int                   OVS_MAX     = 16,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = 79164837,
  parameter int                   DEFAULT_OVS = 16,
  localparam int                  OVS_W       = $clog2(OVS_MAX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 resync,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic [OVS_W-1:0]     cfg_ovs_m1,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 tick_ovs,
  output logic                 baud_tick,
  output logic [OVS_W-1:0]     ovs_phase
);

  localparam logic [OVS_W-1:0] DEF_OVS_M1 = OVS_W'(DEFAULT_OVS - 1);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] inc_act;
  logic [ACC_WIDTH-1:0] inc_sh;
  logic [OVS_W-1:0]     ovs_m1_act;
  logic [OVS_W-1:0]     ovs_m1_sh;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 bit_end;
  logic                 apply_cfg;
  logic                 take_cfg;

  assign sum       = {1'b0, acc} + {1'b0, inc_act};
  assign carry     = sum[ACC_WIDTH];
  assign bit_end   = carry && (ovs_phase == ovs_m1_act);
  // cfg_ready low means the shadow holds a pending config
  assign apply_cfg = !cfg_ready && (!enable || resync || bit_end);
  assign take_cfg  = cfg_valid && cfg_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      inc_act    <= DEFAULT_INC;
      ovs_m1_act <= DEF_OVS_M1;
      inc_sh     <= '0;
      ovs_m1_sh  <= '0;
      cfg_ready  <= 1'b1;
      tick_ovs   <= 1'b0;
      baud_tick  <= 1'b0;
      ovs_phase  <= '0;
    end else begin
      if (!enable || resync) begin
        // a carry coinciding with resync is deliberately discarded
        acc       <= '0;
        ovs_phase <= '0;
        tick_ovs  <= 1'b0;
        baud_tick <= 1'b0;
      end else begin
        acc       <= sum[ACC_WIDTH-1:0];
        tick_ovs  <= carry;
        baud_tick <= bit_end;
        if (carry) begin
          ovs_phase <= bit_end ? '0 : ovs_phase + OVS_W'(1);
        end
      end

      if (apply_cfg) begin
        inc_act    <= inc_sh;
        ovs_m1_act <= ovs_m1_sh;
        cfg_ready  <= 1'b1;
      end else if (take_cfg) begin
        inc_sh     <= cfg_inc;
        ovs_m1_sh  <= cfg_ovs_m1;
        cfg_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - directed and randomized checks of baud_gen_frac against a phase model
module tb_baud_gen_frac;

  localparam int AW = 8;
  localparam int OW = 4;
  localparam int DEF_INC = 40;
  localparam int DEF_OVS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          resync;
  logic [AW-1:0] cfg_inc;
  logic [OW-1:0] cfg_ovs_m1;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          tick_ovs;
  logic          baud_tick;
  logic [OW-1:0] ovs_phase;

  int n_vec = 0;
  int n_err = 0;

  baud_gen_frac #(
    .ACC_WIDTH(AW),
    .OVS_MAX(16),
    .DEFAULT_INC(8'(DEF_INC)),
    .DEFAULT_OVS(DEF_OVS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .resync(resync),
    .cfg_inc(cfg_inc),
    .cfg_ovs_m1(cfg_ovs_m1),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .tick_ovs(tick_ovs),
    .baud_tick(baud_tick),
    .ovs_phase(ovs_phase)
  );

  always #5 clk = ~clk;

  // Reference: unbounded total phase; a tick happens whenever floor(phase/2^AW) grows.
  longint m_phase;
  int     m_inc, m_ovs, m_tib;
  bit     m_pend;
  int     p_inc, p_ovs;
  int     exp_tick, exp_baud;

  task automatic model_reset();
    m_phase = 0; m_inc = DEF_INC; m_ovs = DEF_OVS; m_tib = 0;
    m_pend = 0; p_inc = 0; p_ovs = 1; exp_tick = 0; exp_baud = 0;
  endtask

  task automatic model_edge();
    bit do_take, boundary;
    longint np;
    do_take  = cfg_valid && !m_pend;
    boundary = 0;
    exp_tick = 0;
    exp_baud = 0;
    if (!enable || resync) begin
      m_phase = 0; m_tib = 0; boundary = 1;
    end else begin
      np = m_phase + m_inc;
      if ((np >> AW) != (m_phase >> AW)) begin
        exp_tick = 1;
        m_tib++;
        if (m_tib == m_ovs) begin
          m_tib = 0; exp_baud = 1; boundary = 1;
        end
      end
      m_phase = np;
    end
    if (boundary && m_pend) begin
      m_inc = p_inc; m_ovs = p_ovs; m_pend = 0;
    end
    if (do_take) begin
      p_inc = int'(cfg_inc); p_ovs = int'(cfg_ovs_m1) + 1; m_pend = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("tick_ovs", 32'(tick_ovs), 32'(exp_tick));
    chk("baud_tick", 32'(baud_tick), 32'(exp_baud));
    chk("ovs_phase", 32'(ovs_phase), 32'(m_tib));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // apply a config while idle: one edge to transfer, one to apply
  task automatic cfg_idle(input int inc, input int ovs_m1);
    enable = 0; cfg_valid = 1; cfg_inc = 8'(inc); cfg_ovs_m1 = 4'(ovs_m1);
    step();
    cfg_valid = 0;
    step();
  endtask

  function automatic bit carry_next();
    return ((m_phase + m_inc) >> AW) != (m_phase >> AW);
  endfunction

  initial begin
    int cnt, bcnt, last, k;
    bit seen;

    reset = 1; enable = 0; resync = 0; cfg_valid = 0; cfg_inc = '0; cfg_ovs_m1 = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_outputs();
    reset = 0;

    // 1: inc=64, ovs 4 -> tick every 4 clks, baud every 16
    cfg_idle(64, 3);
    enable = 1;
    cnt = 0; bcnt = 0; last = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (tick_ovs === 1'b1) begin
        chk("t1_gap", 32'(i - last), 32'd4);
        last = i; cnt++;
      end
      if (baud_tick === 1'b1) bcnt++;
    end
    chk("t1_ticks", 32'(cnt), 32'd8);
    chk("t1_bauds", 32'(bcnt), 32'd2);

    // 2: inc=96, ovs 1 -> 3 ticks per 8 clks, gaps 2 or 3
    cfg_idle(96, 0);
    enable = 1;
    cnt = 0; last = 0; seen = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (tick_ovs === 1'b1) begin
        if (seen) chk("t2_gap_ok", 32'((i - last == 2) || (i - last == 3)), 32'd1);
        seen = 1; last = i; cnt++;
      end
    end
    chk("t2_ticks", 32'(cnt), 32'd9);

    // 3: mid-bit reconfig to inc=128, ovs 2
    cfg_idle(64, 3);
    enable = 1;
    k = 0;
    while (m_tib != 1 && k < 40) begin step(); k++; end
    chk("t3_reach_phase1", 32'(m_tib), 32'd1);
    cfg_valid = 1; cfg_inc = 8'd128; cfg_ovs_m1 = 4'd1;
    step();
    cfg_valid = 0;
    k = 0;
    while (cfg_ready !== 1'b1 && k < 40) begin step(); k++; end
    chk("t3_ready_back", 32'(cfg_ready), 32'd1);
    chk("t3_ready_at_baud", 32'(baud_tick), 32'd1);
    cnt = 0; bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick_ovs === 1'b1) cnt++;
      if (baud_tick === 1'b1) bcnt++;
    end
    chk("t3_new_ticks", 32'(cnt), 32'd4);
    chk("t3_new_bauds", 32'(bcnt), 32'd2);

    // 4: resync coincident with a carry
    cfg_idle(64, 3);
    enable = 1;
    k = 0;
    while (!carry_next() && k < 10) begin step(); k++; end
    step();
    k = 0;
    while (!carry_next() && k < 10) begin step(); k++; end
    resync = 1;
    step();
    resync = 0;
    chk("t4_no_tick", 32'(tick_ovs), 32'd0);
    chk("t4_phase0", 32'(ovs_phase), 32'd0);
    k = 0;
    do begin step(); k++; end while (tick_ovs !== 1'b1 && k < 10);
    chk("t4_first_tick_delay", 32'(k), 32'd4);

    // 5: disable mid-bit with a config transfer, then re-enable
    k = 0;
    while (m_tib != 2 && k < 40) begin step(); k++; end
    enable = 0; cfg_valid = 1; cfg_inc = 8'd32; cfg_ovs_m1 = 4'd1;
    step();
    cfg_valid = 0;
    chk("t5_ticks_stop", 32'(tick_ovs), 32'd0);
    chk("t5_ready_low", 32'(cfg_ready), 32'd0);
    step();
    chk("t5_ready_back", 32'(cfg_ready), 32'd1);
    enable = 1;
    k = 0;
    do begin step(); k++; end while (tick_ovs !== 1'b1 && k < 20);
    chk("t5_first_tick_delay", 32'(k), 32'd8);
    chk("t5_first_not_baud", 32'(baud_tick), 32'd0);
    k = 0;
    do begin step(); k++; end while (tick_ovs !== 1'b1 && k < 20);
    chk("t5_second_delay", 32'(k), 32'd8);
    chk("t5_second_baud", 32'(baud_tick), 32'd1);

    // 6: async reset off-edge with a config pending
    k = 0;
    while (m_tib != 1 && k < 40) begin step(); k++; end
    cfg_valid = 1; cfg_inc = 8'd200; cfg_ovs_m1 = 4'd0;
    step();
    cfg_valid = 0;
    step();
    #2 reset = 1;
    #1;
    model_reset();
    chk("t6_tick", 32'(tick_ovs), 32'd0);
    chk("t6_baud", 32'(baud_tick), 32'd0);
    chk("t6_phase", 32'(ovs_phase), 32'd0);
    chk("t6_ready", 32'(cfg_ready), 32'd1);
    #2 reset = 0;
    enable = 1;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (tick_ovs === 1'b1) cnt++;
    end
    chk("t6_default_rate", 32'(cnt), 32'(64 * DEF_INC / 256));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      enable     = ($urandom_range(0, 19) != 0);
      resync     = ($urandom_range(0, 39) == 0);
      cfg_valid  = ($urandom_range(0, 9) == 0);
      cfg_inc    = 8'($urandom);
      cfg_ovs_m1 = 4'($urandom);
      step();
    end
    enable = 0; resync = 0; cfg_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
